// File: rtl/puf_response_capture_if.sv
// puf_response_capture_if: challenge/response handshakes and delay-path pins
// for the arbiter PUF response controller.
interface puf_response_capture_if #(
    parameter int C_LENGTH = 64
);
    logic [C_LENGTH-1:0] Chal_in;
    logic                Chal_valid;
    logic                Chal_ready;
    logic [C_LENGTH-1:0] Challenge;
    logic                Launch;
    logic                Y0;
    logic                Y1;
    logic                Arb;
    logic                Response;
    logic                Resp_err;
    logic                Resp_valid;
    logic                Resp_ready;

    modport slave (
        input  Chal_in, Chal_valid, Y0, Y1, Arb, Resp_ready,
        output Chal_ready, Challenge, Launch, Response, Resp_err, Resp_valid
    );

    modport master (
        output Chal_in, Chal_valid, Y0, Y1, Arb, Resp_ready,
        input  Chal_ready, Challenge, Launch, Response, Resp_err, Resp_valid
    );
endinterface

// File: rtl/puf_response_capture.sv
// puf_response_capture: launches arbiter PUF races and returns the response.
// Define MAJORITY_VOTE_EN to repeat the race NUM_EVAL times and vote.
module puf_response_capture #(
    parameter int C_LENGTH    = 64,
    parameter int SETTLE_CYC  = 4,
    parameter int TIMEOUT_CYC = 32,
    parameter int NUM_EVAL    = 5
) (
    input  logic Clk,
    input  logic Rst_n,
    puf_response_capture_if.slave bus
);
    localparam int MAXC = (SETTLE_CYC > TIMEOUT_CYC) ? SETTLE_CYC : TIMEOUT_CYC;
    localparam int TW = $clog2(MAXC + 1);
    localparam logic [TW-1:0] SETTLE_LAST  = TW'(SETTLE_CYC - 1);
    localparam logic [TW-1:0] TIMEOUT_LAST = TW'(TIMEOUT_CYC - 1);
    // A misconfigured instance refuses every challenge rather than misbehave.
    localparam bit CFG_OK = (SETTLE_CYC >= 1) && (TIMEOUT_CYC >= 1) &&
                            (NUM_EVAL >= 1) && (NUM_EVAL % 2 == 1);

    typedef enum logic [2:0] {
        IDLE, SETTLE, FIRE, WAIT, SAMPLE, RELAX, DECIDE, DONE
    } state_t;

    state_t state, state_nx;
    logic [1:0] sync_y0, sync_y1, sync_arb;
    logic y0_s, y1_s, arb_s;
    logic [TW-1:0] cnt, cnt_nx;
    logic drained, drained_nx;
    logic abort;
    logic chal_ready, chal_ready_nx;
    logic [C_LENGTH-1:0] challenge, challenge_nx;
    logic launch, launch_nx;
    logic response, response_nx;
    logic resp_err, resp_err_nx;
    logic resp_valid, resp_valid_nx;
`ifdef MAJORITY_VOTE_EN
    localparam int EW = $clog2(NUM_EVAL + 1);
    logic [EW-1:0] ones, ones_nx, evals, evals_nx;
`else
    logic arb_q, arb_q_nx;
`endif

    assign y0_s  = sync_y0[1];
    assign y1_s  = sync_y1[1];
    assign arb_s = sync_arb[1];

    assign bus.Chal_ready = chal_ready;
    assign bus.Challenge  = challenge;
    assign bus.Launch     = launch;
    assign bus.Response   = response;
    assign bus.Resp_err   = resp_err;
    assign bus.Resp_valid = resp_valid;

    // Two-flop synchronizers for the asynchronous delay-path outputs.
    always_ff @(posedge Clk) begin
        if (!Rst_n) begin
            sync_y0  <= '0;
            sync_y1  <= '0;
            sync_arb <= '0;
        end else begin
            sync_y0  <= {sync_y0[0], bus.Y0};
            sync_y1  <= {sync_y1[0], bus.Y1};
            sync_arb <= {sync_arb[0], bus.Arb};
        end
    end

    // State, counters and registered outputs.
    always_ff @(posedge Clk) begin
        if (!Rst_n) begin
            state      <= IDLE;
            cnt        <= '0;
            drained    <= 1'b0;
            chal_ready <= 1'b0;
            challenge  <= '0;
            launch     <= 1'b0;
            response   <= 1'b0;
            resp_err   <= 1'b0;
            resp_valid <= 1'b0;
`ifdef MAJORITY_VOTE_EN
            ones       <= '0;
            evals      <= '0;
`else
            arb_q      <= 1'b0;
`endif
        end else begin
            state      <= state_nx;
            cnt        <= cnt_nx;
            drained    <= drained_nx;
            chal_ready <= chal_ready_nx;
            challenge  <= challenge_nx;
            launch     <= launch_nx;
            response   <= response_nx;
            resp_err   <= resp_err_nx;
            resp_valid <= resp_valid_nx;
`ifdef MAJORITY_VOTE_EN
            ones       <= ones_nx;
            evals      <= evals_nx;
`else
            arb_q      <= arb_q_nx;
`endif
        end
    end

    // Next-state and next-output logic for the race sequencer.
    always_comb begin
        state_nx      = state;
        cnt_nx        = cnt;
        drained_nx    = drained;
        abort         = 1'b0;
        challenge_nx  = challenge;
        launch_nx     = launch;
        response_nx   = response;
        resp_err_nx   = resp_err;
        resp_valid_nx = resp_valid;
`ifdef MAJORITY_VOTE_EN
        ones_nx       = ones;
        evals_nx      = evals;
`else
        arb_q_nx      = arb_q;
`endif
        unique case (state)
            IDLE: begin
                if (bus.Chal_valid && chal_ready) begin
                    challenge_nx = bus.Chal_in;
                    cnt_nx       = '0;
                    response_nx  = 1'b0;
                    resp_err_nx  = 1'b0;
`ifdef MAJORITY_VOTE_EN
                    ones_nx      = '0;
                    evals_nx     = '0;
`endif
                    state_nx     = SETTLE;
                end
            end
            SETTLE: begin
                launch_nx = 1'b0;
                if (cnt == SETTLE_LAST) begin
                    cnt_nx   = '0;
                    state_nx = FIRE;
                end else begin
                    cnt_nx = cnt + TW'(1);
                end
            end
            FIRE: begin
                launch_nx = 1'b1;
                cnt_nx    = '0;
                state_nx  = WAIT;
            end
            WAIT: begin
                if (y0_s && y1_s) begin
                    state_nx = SAMPLE;
                end else if (cnt == TIMEOUT_LAST) begin
                    abort = 1'b1;
                end else begin
                    cnt_nx = cnt + TW'(1);
                end
            end
            SAMPLE: begin
                launch_nx  = 1'b0;
                cnt_nx     = '0;
                drained_nx = 1'b0;
`ifdef MAJORITY_VOTE_EN
                ones_nx    = ones + EW'(arb_s);
                evals_nx   = evals + EW'(1);
`else
                arb_q_nx   = arb_s;
`endif
                state_nx   = RELAX;
            end
            RELAX: begin
                if (!drained) begin
                    if (!(y0_s || y1_s)) begin
                        drained_nx = 1'b1;
                        cnt_nx     = '0;
                    end else if (cnt == TIMEOUT_LAST) begin
                        abort = 1'b1;
                    end else begin
                        cnt_nx = cnt + TW'(1);
                    end
                end else if (cnt == SETTLE_LAST) begin
                    cnt_nx = '0;
`ifdef MAJORITY_VOTE_EN
                    state_nx = (evals < EW'(NUM_EVAL)) ? FIRE : DECIDE;
`else
                    state_nx = DECIDE;
`endif
                end else begin
                    cnt_nx = cnt + TW'(1);
                end
            end
            DECIDE: begin
`ifdef MAJORITY_VOTE_EN
                response_nx = (ones > EW'(NUM_EVAL / 2));
`else
                response_nx = arb_q;
`endif
                resp_err_nx   = 1'b0;
                resp_valid_nx = 1'b1;
                state_nx      = DONE;
            end
            DONE: begin
                if (bus.Resp_ready) begin
                    resp_valid_nx = 1'b0;
                    state_nx      = IDLE;
                end
            end
            default: state_nx = IDLE;
        endcase
        // A stuck path ends the whole challenge with an error response.
        if (abort) begin
            resp_err_nx   = 1'b1;
            response_nx   = 1'b0;
            launch_nx     = 1'b0;
            resp_valid_nx = 1'b1;
            state_nx      = DONE;
        end
        chal_ready_nx = (state_nx == IDLE) && CFG_OK;
    end
endmodule

// File: doc/puf_response_capture.md
# puf_response_capture

Response-side controller for the arbiter PUF. It accepts a challenge over a valid/ready handshake and drives the challenge and launch edge into the delay path. It then waits for both racing outputs to arrive, samples the arbiter decision and returns a one-bit response over a second valid/ready handshake. With voting compiled in, the race is repeated and the response is the majority of the evaluations.

## Interface
- `C_LENGTH`, 64: challenge width; equals the delay-path stage count.
- `SETTLE_CYC`, 4: cycles the challenge is held stable with `Launch`=0 before each launch and after each relax; must be ≥1.
- `TIMEOUT_CYC`, 32: maximum cycles to wait for both path outputs after launch; must be ≥1.
- `NUM_EVAL`, 5: evaluations per challenge; must be odd and ≥1. Used only when voting is enabled.

- `Clk`, in, 1: single clock; rising edge.
- `Rst_n`, in, 1: reset; synchronous, active-low.
- `Chal_in`, in, C_LENGTH: challenge to evaluate.
- `Chal_valid`, in, 1: `Chal_in` is valid.
- `Chal_ready`, out, 1: block can accept a challenge.
- `Challenge`, out, C_LENGTH: registered select vector driven to the delay path.
- `Launch`, out, 1: registered race edge driven to the delay path input.
- `Y0`, in, 1: path 0 output; asynchronous.
- `Y1`, in, 1: path 1 output; asynchronous.
- `Arb`, in, 1: arbiter cell decision; asynchronous; 1 means path 0 won.
- `Response`, out, 1: PUF response bit.
- `Resp_err`, out, 1: evaluation timed out; `Response` is invalid.
- `Resp_valid`, out, 1: `Response` and `Resp_err` are valid.
- `Resp_ready`, in, 1: consumer accepts the response.

## Operation
- Reset is synchronous (`Rst_n`=0 at a rising edge) and applies in any state, including mid-race.
  - All outputs reset to 0: `Chal_ready`, `Challenge`, `Launch`, `Response`, `Resp_err`, `Resp_valid`.
  - Counters and synchronizers reset to 0; state goes to IDLE.
- `Y0`, `Y1` and `Arb` each pass through a 2-flop synchronizer. The FSM uses only the synchronized copies `y0_s`, `y1_s`, `arb_s`.
- IDLE: `Chal_ready`=1. When `Chal_valid`&`Chal_ready`, register `Chal_in` into `Challenge`, clear the eval and ones counters, and go to SETTLE.
- SETTLE: `Launch`=0; count `SETTLE_CYC` cycles, then go to FIRE.
- FIRE: set `Launch`=1, clear the timer, go to WAIT.
- WAIT: when `y0_s`&`y1_s`=1, go to SAMPLE.
  - If the timer reaches `TIMEOUT_CYC` first, set `Resp_err`=1 and `Response`=0, drop `Launch`, and go to DONE with no further evaluations.
  - The check happens in the same cycle the timer reaches `TIMEOUT_CYC`. If both the timeout and `y0_s`&`y1_s` occur in that cycle, arrival wins.
- SAMPLE: add `arb_s` to the ones counter, increment the eval counter, set `Launch`=0, go to RELAX.
- RELAX: wait until `y0_s`|`y1_s`=0, then count `SETTLE_CYC` cycles.
  - If the eval count is below `NUM_EVAL`, go to FIRE; otherwise go to DECIDE.
  - A RELAX that never sees both outputs low also times out after `TIMEOUT_CYC` and goes to DONE with `Resp_err`=1.
- DECIDE: `Response` = (ones > `NUM_EVAL`/2, integer division). Go to DONE.
- DONE: `Resp_valid`=1. `Response` and `Resp_err` stay stable until `Resp_valid`&`Resp_ready`, then return to IDLE with `Resp_valid`=0.
- `Challenge` holds its value from acceptance until the next acceptance; it does not change during evaluation.
- `Chal_ready`=0 in every state except IDLE. A challenge cannot be accepted in the cycle a response is consumed.
- Counter widths:
  - ones and eval counters: $clog2(`NUM_EVAL`+1).
  - timer and settle counters: $clog2(max(`SETTLE_CYC`,`TIMEOUT_CYC`)+1).
  - No counter ever wraps.

## Timing
- Reference cycle: accept at edge T.
  - SETTLE occupies edges T+1..T+`SETTLE_CYC`.
  - `Launch` rises at edge T+`SETTLE_CYC`+1.
- Minimum WAIT: 2 cycles of synchronizer latency plus 1 state cycle.
- Ideal single-evaluation latency (inputs respond in 0 ns): accept to `Resp_valid` = 2·`SETTLE_CYC` + 9 cycles, counting RELAX's 2-cycle synchronizer drain.
- `Resp_valid` is registered. Earliest return to IDLE is 1 cycle after a consumed response.
- `Response`, `Resp_err` and `Resp_valid` change only on `Clk` edges, with no combinational path from any input.

## Configuration
- `MAJORITY_VOTE_EN` defined:
  - `NUM_EVAL` evaluations per challenge; majority decision in DECIDE.
  - The first timeout aborts all remaining evaluations.
- `MAJORITY_VOTE_EN` undefined:
  - One evaluation per challenge; `NUM_EVAL` is ignored.
  - DECIDE sets `Response`=`arb_s` as latched in SAMPLE.
  - The ones and eval counters are not synthesized.

## Test plan
- Reset mid-WAIT (`Launch`=1) with `Rst_n`=0 for 1 cycle -> next cycle all outputs 0, `Chal_ready`=1 one cycle after release, no response emitted.
- Voting on, `NUM_EVAL`=5, model with Y0/Y1 following `Launch` after 1 cycle and `Arb` pattern 1,1,0,1,0 -> `Response`=1, `Resp_err`=0, exactly 5 `Launch` pulses, `Challenge`=`Chal_in`=64'hA5A5_0F0F_1234_5678 throughout.
- Same setup with `Arb` pattern 0,0,1,0,1 -> `Response`=0.
- `Y1` tied 0, `TIMEOUT_CYC`=32 -> `Resp_valid` with `Resp_err`=1, `Response`=0, only one `Launch` pulse, `Launch`=0 in DONE.
- `Resp_ready` held 0 for 10 cycles in DONE -> `Resp_valid`, `Response` and `Resp_err` stable; `Chal_valid`=1 not accepted (`Chal_ready`=0); accepted 1 cycle after the consumed response.
- Voting off, `Arb`=1, `SETTLE_CYC`=4 -> one `Launch` pulse, rising exactly 5 cycles after accept; `Response`=1.
